// File: rtl/fetch_redirect_controller.sv
// Purpose: arbitrate branch/jump redirects and stall sources into PC stall/succ/new_addr, plus flush strobes.
// Latency: zero in RUN (outputs combinational from same-cycle inputs); a redirect held in PEND issues in the first mem_stall-free cycle.
// Backpressure: mem_stall parks a redirect in PEND and holds pc_stall high; hazard_stall only stalls when no redirect is issuing.
// Ports: clock/reset (async, active-high); branch_taken/branch_offset (EX), jump_valid/jump_offset (ID);
//        hazard_stall, mem_stall in; pc_stall, pc_succ, pc_offset to the PC; flush_if, flush_id, misaligned strobes;
//        redirect_count, stall_count free-running 32-bit counters.
module fetch_redirect_controller #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_valid,
  input  logic [31:0] jump_offset,
  input  logic        hazard_stall,
  input  logic        mem_stall,
  output logic        pc_stall,
  output logic        pc_succ,
  output logic [31:0] pc_offset,
  output logic        flush_if,
  output logic        flush_id,
  output logic        misaligned,
  output logic [31:0] redirect_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_t;

  // The issue cycle itself is the first of the FLUSH_CYCLES window.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic        pend_br_q, pend_br_d;
  logic [31:0] pend_off_q, pend_off_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic        cand_vld;
  logic [31:0] cand_off;
  logic        cand_bad;
  logic        br_bad;
  logic        issue;
  logic        issue_br;
  logic [31:0] issue_off;
  logic        stall_raw;
  logic        succ_raw;
  logic [31:0] off_raw;
  logic        fif_raw;
  logic        fid_raw;
  logic        mis_raw;

  // A jump alongside a taken branch is on the wrong path, so the branch wins.
  assign cand_vld = branch_taken | jump_valid;
  assign cand_off = branch_taken ? branch_offset : jump_offset;
  assign cand_bad = (cand_off[1:0] != 2'b00);
  assign br_bad   = (branch_offset[1:0] != 2'b00);

  always_comb begin
    state_d          = state_q;
    pend_br_d        = pend_br_q;
    pend_off_d       = pend_off_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_count_d = redirect_count_q;
    issue            = 1'b0;
    issue_br         = 1'b0;
    issue_off        = 32'd0;
    stall_raw        = 1'b0;
    succ_raw         = 1'b0;
    off_raw          = 32'd0;
    fif_raw          = 1'b0;
    fid_raw          = 1'b0;
    mis_raw          = 1'b0;

    case (state_q)
      RUN: begin
        if (cand_vld && cand_bad) begin
          // Misaligned target is dropped: no flush, no count, stalls behave as idle.
          mis_raw   = 1'b1;
          stall_raw = hazard_stall | mem_stall;
        end else if (cand_vld && !mem_stall) begin
          issue     = 1'b1;
          issue_br  = branch_taken;
          issue_off = cand_off;
        end else if (cand_vld) begin
          stall_raw  = 1'b1;
          pend_br_d  = branch_taken;
          pend_off_d = cand_off;
          state_d    = PEND;
        end else begin
          stall_raw = hazard_stall | mem_stall;
        end
      end
      PEND: begin
        if (!mem_stall) begin
          // Pending redirect is older than anything arriving this cycle.
          issue     = 1'b1;
          issue_br  = pend_br_q;
          issue_off = pend_off_q;
        end else begin
          stall_raw = 1'b1;
          if (branch_taken) begin
            if (br_bad) begin
              mis_raw = 1'b1;
            end else begin
              pend_br_d  = 1'b1;
              pend_off_d = branch_offset;
            end
          end
        end
      end
      FLUSH: begin
        // Wrong-path requests and the squashed load consumer are ignored here.
        stall_raw   = mem_stall;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (issue) begin
      succ_raw         = 1'b1;
      off_raw          = issue_off;
      fif_raw          = 1'b1;
      fid_raw          = issue_br;
      redirect_count_d = redirect_count_q + 32'd1;
      flush_cnt_d      = FLUSH_LOAD;
      pend_br_d        = 1'b0;
      pend_off_d       = 32'd0;
      if (FLUSH_CYCLES == 1) begin
        state_d = RUN;
      end else begin
        state_d = FLUSH;
      end
    end
  end

  assign stall_count_d = stall_count_q + {31'd0, stall_raw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      pend_br_q        <= 1'b0;
      pend_off_q       <= 32'd0;
      flush_cnt_q      <= 3'd0;
      redirect_count_q <= 32'd0;
      stall_count_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      pend_br_q        <= pend_br_d;
      pend_off_q       <= pend_off_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_count_q <= redirect_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  // While reset is held nothing may issue, but the PC must still see the raw stall requests.
  assign pc_stall       = reset ? (hazard_stall | mem_stall) : stall_raw;
  assign pc_succ        = reset ? 1'b0  : succ_raw;
  assign pc_offset      = reset ? 32'd0 : off_raw;
  assign flush_if       = reset ? 1'b0  : fif_raw;
  assign flush_id       = reset ? 1'b0  : fid_raw;
  assign misaligned     = reset ? 1'b0  : mis_raw;
  assign redirect_count = redirect_count_q;
  assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_fetch_redirect_controller.sv
module tb_fetch_redirect_controller;

  logic        clock;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_valid;
  logic [31:0] jump_offset;
  logic        hazard_stall;
  logic        mem_stall;
  logic        pc_stall;
  logic        pc_succ;
  logic [31:0] pc_offset;
  logic        flush_if;
  logic        flush_id;
  logic        misaligned;
  logic [31:0] redirect_count;
  logic [31:0] stall_count;

  fetch_redirect_controller #(.FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_offset(jump_offset),
    .hazard_stall(hazard_stall), .mem_stall(mem_stall),
    .pc_stall(pc_stall), .pc_succ(pc_succ), .pc_offset(pc_offset),
    .flush_if(flush_if), .flush_id(flush_id), .misaligned(misaligned),
    .redirect_count(redirect_count), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        bt;
    logic [31:0] bo;
    logic        jv;
    logic [31:0] jo;
    logic        hz;
    logic        ms;
  } stim_t;

  // Per-cycle expected outputs: {pc_stall, pc_succ, flush_if, flush_id, misaligned, pc_offset}.
  typedef struct packed {
    logic        stall;
    logic        succ;
    logic        fif;
    logic        fid;
    logic        mis;
    logic [31:0] off;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks;
  int    n_fail;
  logic [31:0] exp_rc;
  logic [31:0] exp_sc;

  function automatic stim_t s(logic bt, logic [31:0] bo, logic jv, logic [31:0] jo, logic hz, logic ms);
    stim_t r;
    r = '{bt: bt, bo: bo, jv: jv, jo: jo, hz: hz, ms: ms};
    return r;
  endfunction

  function automatic exp_t x(logic stall, logic succ, logic fif, logic fid, logic mis, logic [31:0] off);
    exp_t r;
    r = '{stall: stall, succ: succ, fif: fif, fid: fid, mis: mis, off: off};
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t r;
    r = {pc_stall, pc_succ, flush_if, flush_id, misaligned, pc_offset};
    return r;
  endfunction

  task automatic push(input stim_t st, input exp_t ex);
    stim_q.push_back(st);
    exp_q.push_back(ex);
  endtask

  // Called at posedge+1: apply inputs, then settle to the falling edge for sampling.
  task automatic drive(input stim_t st);
    branch_taken  = st.bt;
    branch_offset = st.bo;
    jump_valid    = st.jv;
    jump_offset   = st.jo;
    hazard_stall  = st.hz;
    mem_stall     = st.ms;
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  localparam exp_t IDLE  = '0;
  localparam stim_t NOP  = '0;

  task automatic test_reset();
    reset = 1'b1;
    drive(NOP);
    advance();
    branch_taken = 1'b1; branch_offset = 32'h6; hazard_stall = 1'b1;
    #1;
    n_checks++;
    if (obs() !== x(1, 0, 0, 0, 0, 32'h0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h required %h", obs(), x(1, 0, 0, 0, 0, 32'h0));
    end
    n_checks++;
    if (redirect_count !== 32'd0 || stall_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got rc=%0d sc=%0d required 0 0", redirect_count, stall_count);
    end
    branch_taken = 1'b0; hazard_stall = 1'b0; mem_stall = 1'b1;
    #1;
    n_checks++;
    if (pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_mem_stall: got %b required 1", pc_stall);
    end
    mem_stall = 1'b0;
    #1;
    n_checks++;
    if (pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_stall: got %b required 0", pc_stall);
    end
    @(negedge clock);
    reset = 1'b0;
    advance();
    exp_rc = 32'd0;
    exp_sc = 32'd0;
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL post_reset_counters: got rc=%0d sc=%0d required 0 0", redirect_count, stall_count);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    push(s(1, 32'h10, 0, 32'h0, 0, 0), x(0, 1, 1, 1, 0, 32'h10));
    push(s(0, 32'h0, 1, 32'h40, 0, 0), IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL branch: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== 32'd1) begin
      n_fail++; $display("FAIL branch_rc: got %0d required 1", redirect_count);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    push(s(1, 32'h20, 1, 32'h40, 0, 0), x(0, 1, 1, 1, 0, 32'h20));
    push(s(0, 32'h0, 1, 32'h40, 0, 0), IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL priority: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== exp_rc) begin
      n_fail++; $display("FAIL priority_rc: got %0d required %0d", redirect_count, exp_rc);
    end
  endtask

  task automatic test_pend_jump();
    exp_t e;
    push(s(0, 32'h0, 1, 32'h8, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(s(0, 32'h0, 0, 32'h0, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(s(0, 32'h0, 1, 32'h44, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(NOP, x(0, 1, 1, 0, 0, 32'h8));
    push(NOP, IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL pend_jump: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (stall_count !== 32'd3) begin
      n_fail++; $display("FAIL pend_jump_sc: got %0d required 3", stall_count);
    end
    n_checks++;
    if (redirect_count !== exp_rc) begin
      n_fail++; $display("FAIL pend_jump_rc: got %0d required %0d", redirect_count, exp_rc);
    end
  endtask

  task automatic test_pend_replace();
    exp_t e;
    push(s(0, 32'h0, 1, 32'h8, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(s(1, 32'h30, 0, 32'h0, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(s(1, 32'h50, 0, 32'h0, 0, 0), x(0, 1, 1, 1, 0, 32'h30));
    push(NOP, IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL pend_replace: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL pend_replace_counters: got rc=%0d sc=%0d required %0d %0d",
                         redirect_count, stall_count, exp_rc, exp_sc);
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    push(s(0, 32'h0, 0, 32'h0, 1, 0), x(1, 0, 0, 0, 0, 32'h0));
    push(s(1, 32'hC, 0, 32'h0, 1, 0), x(0, 1, 1, 1, 0, 32'hC));
    push(s(0, 32'h0, 0, 32'h0, 1, 0), IDLE);
    push(s(0, 32'h0, 0, 32'h0, 1, 0), x(1, 0, 0, 0, 0, 32'h0));
    push(s(1, 32'h4, 0, 32'h0, 0, 0), x(0, 1, 1, 1, 0, 32'h4));
    push(s(1, 32'h8, 0, 32'h0, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL hazard: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL hazard_counters: got rc=%0d sc=%0d required %0d %0d",
                         redirect_count, stall_count, exp_rc, exp_sc);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    push(s(1, 32'h6, 0, 32'h0, 0, 0), x(0, 0, 0, 0, 1, 32'h0));
    push(s(0, 32'h0, 1, 32'h2, 1, 0), x(1, 0, 0, 0, 1, 32'h0));
    push(NOP, IDLE);
    push(s(0, 32'h0, 1, 32'h0, 0, 0), x(0, 1, 1, 0, 0, 32'h0));
    push(NOP, IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL misaligned: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL misaligned_counters: got rc=%0d sc=%0d required %0d %0d",
                         redirect_count, stall_count, exp_rc, exp_sc);
    end
  endtask

  task automatic test_reset_pend();
    exp_t e;
    push(s(0, 32'h0, 1, 32'h8, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    push(s(0, 32'h0, 0, 32'h0, 0, 1), x(1, 0, 0, 0, 0, 32'h0));
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL reset_pend_setup: got %h required %h", obs(), e);
      end
      advance();
    end
    #2;
    reset = 1'b1;
    #1;
    exp_rc = 32'd0;
    exp_sc = 32'd0;
    n_checks++;
    if (obs() !== x(1, 0, 0, 0, 0, 32'h0)) begin
      n_fail++; $display("FAIL reset_pend_async: got %h required %h", obs(), x(1, 0, 0, 0, 0, 32'h0));
    end
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL reset_pend_counters: got rc=%0d sc=%0d required 0 0", redirect_count, stall_count);
    end
    mem_stall = 1'b0;
    #1;
    n_checks++;
    if (obs() !== IDLE) begin
      n_fail++; $display("FAIL reset_pend_idle: got %h required %h", obs(), IDLE);
    end
    @(negedge clock);
    reset = 1'b0;
    advance();
    push(NOP, IDLE);
    push(NOP, IDLE);
    push(NOP, IDLE);
    while (stim_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(stim_q.pop_front());
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL reset_pend_after: got %h required %h", obs(), e);
      end
      exp_rc += 32'(e.succ); exp_sc += 32'(e.stall);
      advance();
    end
    n_checks++;
    if (redirect_count !== exp_rc || stall_count !== exp_sc) begin
      n_fail++; $display("FAIL reset_pend_final: got rc=%0d sc=%0d required %0d %0d",
                         redirect_count, stall_count, exp_rc, exp_sc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_rc   = 32'd0;
    exp_sc   = 32'd0;
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_offset = 32'd0;
    jump_valid    = 1'b0;
    jump_offset   = 32'd0;
    hazard_stall  = 1'b0;
    mem_stall     = 1'b0;
    test_reset();
    test_branch();
    test_priority();
    test_pend_jump();
    test_pend_replace();
    test_hazard();
    test_misaligned();
    test_reset_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
